cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NREQ result producers (ALU, load unit, branch unit).
- Each producer hands its result into a private one-entry holding slot over a valid/ready handshake.
- A round-robin scheduler broadcasts one held result per cycle as a registered (flag, rob_id, val) triple.
- Register file, reservation stations and ROB sample that triple; a mispredict flush drops everything in flight.

Parameters:
- NREQ, 3, number of requesters; index 0 = ALU, 1 = load, 2 = branch.
- IDW, 32, ROB id width.
- DW, 32, result value width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets all state.
- rdy  in  1  global ready; 0 freezes all state.
- jump_wrong_stall  in  1  mispredict flush.
- req_valid  in  NREQ  per-requester result valid.
- req_rob_id  in  NREQ*IDW  packed ROB ids; requester i uses bits [i*IDW +: IDW].
- req_val  in  NREQ*DW  packed result values.
- req_ready  out  NREQ  combinational; slot i can accept this cycle.
- cdb_flag  out  1  registered broadcast valid.
- cdb_rob_id  out  IDW  registered broadcast ROB id.
- cdb_val  out  DW  registered broadcast value.
- cdb_src  out  log2(NREQ)  registered index of the requester that produced the broadcast.

Behaviour:
- State:
  - Per slot i: slot_v[i], slot_id[i], slot_val[i].
  - rr_ptr in 0..NREQ-1.
  - Output registers: cdb_flag, cdb_rob_id, cdb_val, cdb_src.
- Update priority each edge: reset (rst==0) > freeze (rdy==0) > flush (jump_wrong_stall==1) > normal.
  - Reset applies even while rdy==0.
- Reset values: slot_v=0, slot_id=0, slot_val=0, rr_ptr=0, cdb_flag=0, cdb_rob_id=0, cdb_val=0, cdb_src=0.
- Combinational grant:
  - Scan slots rr_ptr, rr_ptr+1, ... modulo NREQ.
  - The first i with slot_v[i]==1 is the winner; grant_v=1.
  - No valid slot gives grant_v=0.
- req_ready[i] = rst && rdy && !jump_wrong_stall && (!slot_v[i] || (grant_v && winner==i)).
  - req_ready[i] must not depend on req_valid.
- Normal edge, for each slot i:
  - Accept (req_valid[i] && req_ready[i]): slot_v[i]<=1 and capture id/val.
  - Else if i is the winner: slot_v[i]<=0.
  - Accept plus grant on the same slot in the same cycle: the old contents go to the CDB and the new contents load into the slot. There is no loss and no duplication.
- Normal edge, outputs:
  - grant_v==1: cdb_flag<=1; cdb_rob_id, cdb_val and cdb_src <= winner slot contents and index; rr_ptr<=winner+1, wrapping NREQ-1 to 0.
  - grant_v==0: cdb_flag<=0; cdb_rob_id, cdb_val and cdb_src hold; rr_ptr holds.
- Latency: a result accepted at edge E is on the CDB no earlier than edge E+1, i.e. visible in the cycle after E+1.
- Throughput: one broadcast per cycle when any slot is valid.
- Fairness: a valid slot is granted within NREQ cycles.
- Backpressure: a requester whose slot is held and not granted sees req_ready=0 and must hold req_valid and its data stable.
- Flush edge:
  - All slot_v<=0, cdb_flag<=0, rr_ptr<=0; ids and values hold.
  - Requests presented in the flush cycle are not accepted.
- Freeze (rdy==0): all state holds, including cdb_flag, and req_ready=0.
- A rob_id value of 0 is legal and is not treated specially.

Test Plan:
- Reset with rst=0 for 2 cycles -> cdb_flag=0, cdb_rob_id=0, req_ready=0 while rst=0; req_ready=3'b111 in the first cycle after rst=1, rdy=1.
- Single ALU request: req_valid=001, id=5, val=0x1234 for one cycle -> cdb_flag=1, cdb_rob_id=5, cdb_val=0x1234, cdb_src=0 exactly one cycle, then cdb_flag=0.
- All three requesters valid simultaneously (ids 1, 2, 3), each held until accepted -> broadcasts in order src 0, 1, 2 on consecutive cycles with ids 1, 2, 3; rr_ptr wraps to 0.
- ALU streams back-to-back (ids 10, 11, 12, ...) while load holds id 20 -> load broadcast appears within 3 cycles; no ALU id is dropped or duplicated; ALU ids appear in order.
- Slots 1 and 2 full, jump_wrong_stall=1 for one cycle -> cdb_flag=0 next cycle; neither held id is ever broadcast; a new request after the flush broadcasts normally.
- rdy=0 for 4 cycles with cdb_flag=1, id=7 and slot 2 full -> outputs hold id 7 and req_ready=0; after rdy=1, slot 2 broadcasts on the next edge.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Producer-to-arbiter result handshake plus the registered CDB broadcast triple.
// The master side drives requests and samples the bus; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int IDW  = 32,
  parameter int DW   = 32
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*IDW-1:0] req_rob_id;
  logic [NREQ*DW-1:0]  req_val;
  logic [NREQ-1:0]     req_ready;
  logic                cdb_flag;
  logic [IDW-1:0]      cdb_rob_id;
  logic [DW-1:0]       cdb_val;
  logic [SW-1:0]       cdb_src;

  modport master (
    output req_valid, req_rob_id, req_val,
    input  req_ready, cdb_flag, cdb_rob_id, cdb_val, cdb_src
  );

  modport slave (
    input  req_valid, req_rob_id, req_val,
    output req_ready, cdb_flag, cdb_rob_id, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin share of one CDB among NREQ one-entry result slots; broadcast registered one edge after accept.
// A held slot drops req_ready until it wins the bus; rdy==0 freezes everything, a flush empties all slots.
module cdb_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 32,
  parameter int DW   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         jump_wrong_stall,
  cdb_arbiter_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [IDW-1:0] rob_id;
    logic [DW-1:0]  val;
  } slot_t;

  logic [NREQ-1:0] slot_v;
  slot_t           slot_q [NREQ];
  logic [SW-1:0]   rr_ptr;

  logic            grant_v;
  logic [SW-1:0]   winner;
  logic [SW:0]     scan_idx;
  logic            active;
  logic [NREQ-1:0] ready;

  logic            cdb_flag_q;
  logic [IDW-1:0]  cdb_rob_id_q;
  logic [DW-1:0]   cdb_val_q;
  logic [SW-1:0]   cdb_src_q;

  // Scan from rr_ptr upward, wrapping, and keep the first occupied slot.
  always_comb begin
    grant_v  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SW+1)'(k);
      if (scan_idx >= (SW+1)'(NREQ)) begin
        scan_idx = scan_idx - (SW+1)'(NREQ);
      end
      if (!grant_v && slot_v[scan_idx[SW-1:0]]) begin
        grant_v = 1'b1;
        winner  = scan_idx[SW-1:0];
      end
    end
  end

  // A slot being drained this cycle may refill on the same edge.
  always_comb begin
    active = rst && rdy && !jump_wrong_stall;
    ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready[i] = active && (!slot_v[i] || (grant_v && (winner == SW'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_v       <= '0;
      rr_ptr       <= '0;
      cdb_flag_q   <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i] <= '0;
      end
    end else if (rdy) begin
      if (jump_wrong_stall) begin
        slot_v     <= '0;
        rr_ptr     <= '0;
        cdb_flag_q <= 1'b0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_valid[i] && ready[i]) begin
            slot_v[i]        <= 1'b1;
            slot_q[i].rob_id <= bus.req_rob_id[i*IDW +: IDW];
            slot_q[i].val    <= bus.req_val[i*DW +: DW];
          end else if (grant_v && (winner == SW'(i))) begin
            slot_v[i] <= 1'b0;
          end
        end
        if (grant_v) begin
          cdb_flag_q   <= 1'b1;
          cdb_rob_id_q <= slot_q[winner].rob_id;
          cdb_val_q    <= slot_q[winner].val;
          cdb_src_q    <= winner;
          rr_ptr       <= (winner == SW'(NREQ-1)) ? '0 : winner + SW'(1);
        end else begin
          cdb_flag_q <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.cdb_flag   = cdb_flag_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_val    = cdb_val_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule
